// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and channel geometry for the mux scan sequencer.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        VALID  = 2'd3
    } state_e;
endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// settle_timer: loadable down-counter that flags when the select settle time has elapsed.
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? value : dec ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux through its channels, samples d after a settle
// time and hands the assembled 4-bit word to a consumer over valid/ready.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       d,
    output logic       s1,
    output logic       s0,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
);
    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] cap_q, cap_d;
    logic [3:0]        word_q, word_d;
    logic              load, dec, settled;

    settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (CNT_W'(SETTLE_CYCLES - 1)),
        .dec   (dec),
        .zero  (settled)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cap_d   = cap_q;
        word_d  = word_q;
        load    = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SETTLE;
                ch_d    = '0;
                load    = 1'b1;
            end
            SETTLE: if (settled) state_d = SAMPLE;
                    else         dec     = 1'b1;
            SAMPLE: begin
                cap_d[ch_q] = d;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    word_d  = cap_d;
                    ch_d    = '0;
                    state_d = VALID;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    load    = 1'b1;
                    state_d = SETTLE;
                end
            end
            VALID: if (word_ready) begin
                // continuous is only looked at here, so clearing it mid-scan lets the scan finish
                state_d = continuous ? SETTLE : IDLE;
                load    = continuous;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cap_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cap_q   <= cap_d;
            word_q  <= word_d;
        end

    assign {s1, s0}   = ch_q;
    assign word       = word_q;
    assign word_valid = (state_q == VALID);
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed scans against a behavioural 4:1 mux, with a
// scoreboard checking every presented word and its completion cycle.
module tb_mux_scan_sequencer;
    typedef struct {
        logic [3:0] w;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       word_ready = 1'b1;
    logic [3:0] inp = 4'b0000;
    logic       d, s1, s0, word_valid, busy;
    logic [3:0] word;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       expq[$];

    mux_scan_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .d          (d),
        .s1         (s1),
        .s0         (s0),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    assign d = inp[{s1, s0}];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every rising word_valid must match the oldest expectation.
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (word_valid && !pv) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", word, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("word", int'(word), int'(e.w));
                chk("valid_cycle", cyc, e.c);
            end
        end
        pv = word_valid;
    end

    // mode: 0 plain, 1 glitch i1 during channel-1 settle, 2 extra start pulses, 3 reset in channel-2 settle
    task automatic scan(input logic [3:0] iv, input logic [3:0] ew, input int mode,
                        input bit push, output int e);
        @(negedge clk);
        inp   = iv;
        start = 1'b1;
        e     = cyc + 1;
        if (push) expq.push_back('{ew, e + 12});
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("select", int'({s1, s0}), k / 3);
            chk("busy_scan", int'(busy), 1);
            if (mode == 1) begin
                if (k == 3 || k == 4) inp[1] = 1'b1;
                if (k == 5) inp[1] = 1'b0;
                if (k == 6) inp[1] = 1'b1;
            end
            if (mode == 2) start = (k == 2 || k == 7);
            if (mode == 3 && k == 7) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_sel", int'({s1, s0}), 0);
                chk("rst_word", int'(word), 0);
                chk("rst_valid", int'(word_valid), 0);
                chk("rst_busy", int'(busy), 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int e;
        repeat (2) @(negedge clk);
        chk("reset_sel", int'({s1, s0}), 0);
        chk("reset_word", int'(word), 0);
        chk("reset_valid", int'(word_valid), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scan(4'b1101, 4'b1101, 0, 1'b1, e);
        repeat (2) @(negedge clk);
        chk("idle_after_basic", int'(busy), 0);

        scan(4'b0101, 4'b0101, 1, 1'b1, e);
        repeat (2) @(negedge clk);

        word_ready = 1'b0;
        scan(4'b0110, 4'b0110, 0, 1'b1, e);
        for (int n = 0; n < 10; n++) begin
            chk("bp_valid", int'(word_valid), 1);
            chk("bp_word", int'(word), 4'b0110);
            chk("bp_sel", int'({s1, s0}), 0);
            chk("bp_busy", int'(busy), 1);
            @(negedge clk);
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        chk("bp_valid_drop", int'(word_valid), 0);
        chk("bp_idle", int'(busy), 0);
        chk("bp_word_hold", int'(word), 4'b0110);
        word_ready = 1'b1;
        repeat (2) @(negedge clk);

        continuous = 1'b1;
        scan(4'b0000, 4'b0000, 0, 1'b1, e);
        inp = 4'b1111;
        expq.push_back('{4'b1111, e + 25});
        @(negedge clk);
        chk("cont_no_idle", int'(busy), 1);
        chk("cont_valid_drop", int'(word_valid), 0);
        continuous = 1'b0;
        repeat (20) @(negedge clk);
        chk("cont_stops", int'(busy), 0);
        chk("cont_last_word", int'(word), 4'b1111);

        scan(4'b1010, 4'b1010, 2, 1'b1, e);
        repeat (20) @(negedge clk);
        chk("one_word_only", int'(busy), 0);

        scan(4'b0111, 4'b0000, 3, 1'b0, e);
        repeat (2) @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        scan(4'b1000, 4'b1000, 0, 1'b1, e);
        repeat (3) @(negedge clk);
        chk("pending_words", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sits directly upstream of the 4:1 mux (select inputs s1/s0, data inputs i0..i3, output d).
- Drives s1/s0 through channels 0..3 in order.
- After each select change it waits a programmable settle time, then samples d.
- It assembles the four samples into a 4-bit word and presents it on a valid/ready handshake; one-shot and continuous scan modes.

Parameters:
- SETTLE_CYCLES, 2, cycles select is held before sampling; legal range 1..15.
- CNT_W, 4, width of settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE
- continuous  input  1  when 1, a new scan starts automatically after each accepted word
- d  input  1  mux output being sampled
- s1  output  1  select MSB to mux
- s0  output  1  select LSB to mux
- word  output  4  bit n = sample of channel n (i0 -> word[0] ... i3 -> word[3])
- word_valid  output  1  word holds a complete scan result
- word_ready  input  1  consumer accepts word when word_valid & word_ready
- busy  output  1  1 in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low. While rst_n=0, outputs are forced low:
  - state=IDLE, s1=s0=0, word=0, word_valid=0, busy=0.
  - Internal capture register and counter are cleared.
- Reset asserted mid-scan aborts the scan immediately. No partial word is ever presented.
- State encoding: IDLE, SETTLE, SAMPLE, VALID.
- Select: {s1,s0} = internal 2-bit channel index ch, registered. ch=0 in IDLE and VALID.
- IDLE:
  - start=1 at an edge -> SETTLE, ch=0, counter=SETTLE_CYCLES-1.
  - start is ignored in all other states (no queuing).
- SETTLE:
  - Counter decrements each cycle; at 0 -> SAMPLE.
  - ch is held stable for exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - At the ending edge, cap[ch] <= d.
  - If ch<3: ch <= ch+1, counter reloads, -> SETTLE.
  - If ch==3: word <= {d, cap[2:0]}, word_valid <= 1, ch <= 0, -> VALID.
- Timing per channel: SETTLE_CYCLES+1 cycles.
- Latency: if start is sampled at edge E, word_valid rises at edge E+4*(SETTLE_CYCLES+1). With the default this is 12 cycles.
- VALID:
  - word and word_valid are held stable until transfer.
  - Transfer = word_valid & word_ready at an edge.
  - On transfer: word_valid <= 0.
    - continuous=1 -> SETTLE (ch=0, counter reloaded), with no idle cycle.
    - continuous=0 -> IDLE.
  - word keeps its last value after transfer until the next scan completes.
  - word_ready is ignored outside VALID.
- Back-pressure: no sampling occurs while in VALID. No data loss and no overrun are possible.
- continuous is sampled only at the transfer edge. Deasserting it mid-scan finishes the current scan and then stops.
- Data path: d is not synchronised inside the block; the mux is same-clock combinational logic.

Decomposition:
- Shared package mux_scan_pkg:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, VALID=2'd3)
  - NUM_CH=4, CH_W=2
- One sub-module, settle_timer (parameter CNT_W):
  - load/value/dec inputs, zero output
  - async active-low reset on the same clk/rst_n
- FSM, channel index and capture register stay in the top module.

Test Plan:
- Mux model i0..i3=1,0,1,1 with SETTLE_CYCLES=2, start pulse, word_ready=1 -> word_valid rises exactly 12 cycles after start edge with word=4'b1101; {s1,s0} steps 00,01,10,11, each held 3 cycles.
- Settle honour: change i1 during cycles 1-2 of channel-1 settle, final value 0 at sample cycle -> word[1]=0. Also check d is never captured before the SAMPLE state.
- Back-pressure: word_ready=0 for 10 cycles after valid -> word and valid are stable, s1=s0=0, busy=1. Ready pulse -> valid drops next edge and block returns to IDLE.
- Continuous mode: continuous=1, ready=1, inputs change between scans (0000, then 1111) -> successive words 0000, 1111. SETTLE follows transfer with no idle cycle.
- Start during scan: extra start pulses mid-scan -> exactly one word produced; timing unchanged.
- Reset mid-operation: assert rst_n=0 asynchronously during channel-2 settle -> outputs zero immediately, without waiting for a clock edge. After release plus start -> clean full 12-cycle scan, with no stale capture bits in word.
